// File: rtl/instruction_type_s_pkg.sv
// Shared decode constants, FSM encoding and S-immediate extraction for the store path.
package instruction_type_s_pkg;

  localparam logic [6:0] OPCODE_S = 7'h23;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Split immediate: ir[31:25] is imm[11:5], ir[11:7] is imm[4:0].
  function automatic logic [31:0] sImm(input logic [6:0] immHi, input logic [4:0] immLo);
    return {{20{immHi[6]}}, immHi, immLo};
  endfunction

endpackage

// File: rtl/instruction_type_s_store_merge.sv
// Combinational sub-word merge: folds rs2 into an existing RAM word for stores
// into memory that has no byte enables.
module store_merge
  import instruction_type_s_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] rs2,
  input  logic [2:0]  func3,
  input  logic [1:0]  addrLo,
  output logic [31:0] mergedWord
);

  always_comb begin
    mergedWord = oldWord;
    case (func3)
      F3_SB: begin
        case (addrLo)
          2'd0:    mergedWord[7:0]   = rs2[7:0];
          2'd1:    mergedWord[15:8]  = rs2[7:0];
          2'd2:    mergedWord[23:16] = rs2[7:0];
          default: mergedWord[31:24] = rs2[7:0];
        endcase
      end
      F3_SH: begin
        if (addrLo[1]) mergedWord[31:16] = rs2[15:0];
        else           mergedWord[15:0]  = rs2[15:0];
      end
      F3_SW:   mergedWord = rs2;
      default: mergedWord = oldWord;
    endcase
  end

endmodule

// File: rtl/instruction_type_s.sv
// S-type store unit: SW is a single write, SB/SH do read-modify-write on a
// word-wide RAM. All handshake and RAM outputs are registered.
//
// state | meaning
// IDLE  | waiting for iSTART; decode and alignment checked on the accepting edge
// READ  | RAM read of the aligned word (SB/SH only)
// MERGE | read data returns; rs2 is folded into the old word
// WRITE | RAM write of rs2 (SW) or the merged word (SB/SH)
// DONE  | oDONE pulse
// ERR   | oERR pulse, no RAM access
module instruction_type_s
  import instruction_type_s_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iIR,
  output logic [4:0]  oRS1,
  output logic [4:0]  oRS2,
  input  logic [31:0] iREG_OUT1,
  input  logic [31:0] iREG_OUT2,
  input  logic        iSTART,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic        oRAM_CE,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA
);

  state_t state, nextState;

  logic [31:0] ea, eaQ, rs2Q, merged, addrNext, writeData;
  logic [2:0]  func3, func3Q;
  logic        opOk, f3Legal, aligned;
  logic        busyQ, doneQ, errQ, ceQ, wrQ;
  logic [31:0] addrQ, dataQ;

  assign oRS1  = iIR[19:15];
  assign oRS2  = iIR[24:20];
  assign func3 = iIR[14:12];
  assign opOk  = (iIR[6:0] == OPCODE_S);
  assign ea    = iREG_OUT1 + sImm(iIR[31:25], iIR[11:7]);

  always_comb begin
    f3Legal = 1'b1;
    aligned = 1'b1;
    case (func3)
      F3_SB:   aligned = 1'b1;
      F3_SH:   aligned = ~ea[0];
      F3_SW:   aligned = (ea[1:0] == 2'b00);
      default: f3Legal = 1'b0;
    endcase
  end

  store_merge uMerge (
    .oldWord    (iRAM_DATA),
    .rs2        (rs2Q),
    .func3      (func3Q),
    .addrLo     (eaQ[1:0]),
    .mergedWord (merged)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (iSTART) begin
          if (!opOk || !f3Legal || !aligned) nextState = ERR;
          else if (func3 == F3_SW)           nextState = WRITE;
          else                               nextState = READ;
        end
      end
      READ:    nextState = MERGE;
      MERGE:   nextState = WRITE;
      WRITE:   nextState = DONE;
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // From IDLE the live decode feeds the first RAM cycle; afterwards the latched copies do.
  always_comb begin
    addrNext  = {eaQ[31:2], 2'b00};
    writeData = merged;
    if (state == IDLE) begin
      addrNext  = {ea[31:2], 2'b00};
      writeData = iREG_OUT2;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      eaQ    <= '0;
      rs2Q   <= '0;
      func3Q <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
      ceQ    <= 1'b0;
      wrQ    <= 1'b0;
      addrQ  <= '0;
      dataQ  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && iSTART) begin
        eaQ    <= ea;
        rs2Q   <= iREG_OUT2;
        func3Q <= func3;
      end
      busyQ <= (nextState != IDLE);
      doneQ <= (nextState == DONE);
      errQ  <= (nextState == ERR);
      ceQ   <= (nextState == READ) || (nextState == WRITE);
      wrQ   <= (nextState == WRITE);
      if (nextState == READ || nextState == WRITE) addrQ <= addrNext;
      if (nextState == WRITE) dataQ <= writeData;
    end
  end

  assign oBUSY     = busyQ;
  assign oDONE     = doneQ;
  assign oERR      = errQ;
  assign oRAM_CE   = ceQ;
  assign oRAM_WR   = wrQ;
  assign oRAM_ADDR = addrQ;
  assign oRAM_DATA = dataQ;

endmodule

// File: tb/tb_instruction_type_s.sv
// Directed bench for the S-type store unit with a one-cycle-latency RAM model.
module tb_instruction_type_s;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [31:0] iIR = '0;
  logic [4:0]  oRS1, oRS2;
  logic [31:0] iREG_OUT1 = '0;
  logic [31:0] iREG_OUT2 = '0;
  logic        iSTART = 1'b0;
  logic        oBUSY, oDONE, oERR, oRAM_CE, oRAM_WR;
  logic [31:0] oRAM_ADDR, oRAM_DATA;
  logic [31:0] iRAM_DATA = '0;

  int errors = 0;
  int checks = 0;
  int writeCnt = 0;
  int doneCnt = 0;
  int ceCnt = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  ramIdx;

  // Output vector order: {CE, WR, BUSY, DONE, ERR}
  localparam logic [4:0] S_IDLE  = 5'b00000;
  localparam logic [4:0] S_READ  = 5'b10100;
  localparam logic [4:0] S_MERGE = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b11100;
  localparam logic [4:0] S_DONE  = 5'b00110;
  localparam logic [4:0] S_ERR   = 5'b00101;

  always #5 iCLK = ~iCLK;

  instruction_type_s dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iIR       (iIR),
    .oRS1      (oRS1),
    .oRS2      (oRS2),
    .iREG_OUT1 (iREG_OUT1),
    .iREG_OUT2 (iREG_OUT2),
    .iSTART    (iSTART),
    .oBUSY     (oBUSY),
    .oDONE     (oDONE),
    .oERR      (oERR),
    .oRAM_CE   (oRAM_CE),
    .oRAM_WR   (oRAM_WR),
    .oRAM_ADDR (oRAM_ADDR),
    .oRAM_DATA (oRAM_DATA),
    .iRAM_DATA (iRAM_DATA)
  );

  assign ramIdx = oRAM_ADDR[11:2];

  always @(posedge iCLK) begin
    if (oRAM_CE && !oRAM_WR) iRAM_DATA <= mem[ramIdx];
    if (oRAM_CE && oRAM_WR) begin
      mem[ramIdx] = oRAM_DATA;
      writeCnt++;
    end
    if (oRAM_CE) ceCnt++;
    if (oDONE) doneCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, oRAM_CE, oRAM_WR, oBUSY, oDONE, oERR}, {27'd0, exp});
  endtask

  function automatic logic [31:0] sInst(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  // Drives a one-cycle start; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [31:0] ir, input logic [31:0] r1, input logic [31:0] r2);
    @(negedge iCLK);
    iIR = ir;
    iREG_OUT1 = r1;
    iREG_OUT2 = r2;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  initial begin
    int w0, c0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h080] = 32'h11223344;
    mem[10'h07F] = 32'hAABBCCDD;
    mem[10'h050] = 32'hCAFEF00D;

    repeat (2) @(negedge iCLK);
    expectOut("reset_outputs", S_IDLE);
    chk("reset_addr", oRAM_ADDR, 32'h0);
    chk("reset_data", oRAM_DATA, 32'h0);
    iRST = 1'b0;

    // SW: 0x100 + 8
    iIR = sInst(12'h008, 5'd7, 5'd5, 3'd2, 7'h23);
    #1;
    chk("decode_rs1", {27'd0, oRS1}, 32'd5);
    chk("decode_rs2", {27'd0, oRS2}, 32'd7);
    issue(sInst(12'h008, 5'd7, 5'd5, 3'd2, 7'h23), 32'h100, 32'hDEADBEEF);
    expectOut("sw_write", S_WRITE);
    chk("sw_addr", oRAM_ADDR, 32'h108);
    chk("sw_data", oRAM_DATA, 32'hDEADBEEF);
    @(negedge iCLK);
    expectOut("sw_done", S_DONE);
    chk("sw_addr_hold", oRAM_ADDR, 32'h108);
    @(negedge iCLK);
    expectOut("sw_idle", S_IDLE);
    chk("sw_mem", mem[10'h042], 32'hDEADBEEF);

    // SB into byte lane 2 of 0x200
    issue(sInst(12'h002, 5'd8, 5'd6, 3'd0, 7'h23), 32'h200, 32'h123456AB);
    expectOut("sb_read", S_READ);
    chk("sb_read_addr", oRAM_ADDR, 32'h200);
    @(negedge iCLK);
    expectOut("sb_merge", S_MERGE);
    @(negedge iCLK);
    expectOut("sb_write", S_WRITE);
    chk("sb_data", oRAM_DATA, 32'h11AB3344);
    @(negedge iCLK);
    expectOut("sb_done", S_DONE);
    @(negedge iCLK);
    expectOut("sb_idle", S_IDLE);
    chk("sb_mem", mem[10'h080], 32'h11AB3344);

    // SH, negative immediate: ea = 0x1FE -> upper half of 0x1FC
    issue(sInst(12'hFFE, 5'd9, 5'd6, 3'd1, 7'h23), 32'h200, 32'h00005566);
    expectOut("sh_read", S_READ);
    chk("sh_read_addr", oRAM_ADDR, 32'h1FC);
    repeat (2) @(negedge iCLK);
    expectOut("sh_write", S_WRITE);
    chk("sh_addr", oRAM_ADDR, 32'h1FC);
    chk("sh_data", oRAM_DATA, 32'h5566CCDD);
    @(negedge iCLK);
    expectOut("sh_done", S_DONE);
    @(negedge iCLK);
    chk("sh_mem", mem[10'h07F], 32'h5566CCDD);

    // Error cases: no RAM activity allowed
    c0 = ceCnt;
    issue(sInst(12'h002, 5'd1, 5'd2, 3'd2, 7'h23), 32'h100, 32'h1);
    expectOut("sw_misaligned_err", S_ERR);
    @(negedge iCLK);
    expectOut("sw_misaligned_idle", S_IDLE);
    issue(sInst(12'h001, 5'd1, 5'd2, 3'd1, 7'h23), 32'h100, 32'h1);
    expectOut("sh_misaligned_err", S_ERR);
    @(negedge iCLK);
    issue(sInst(12'h000, 5'd1, 5'd2, 3'd3, 7'h23), 32'h100, 32'h1);
    expectOut("illegal_f3_err", S_ERR);
    @(negedge iCLK);
    issue(sInst(12'h000, 5'd1, 5'd2, 3'd2, 7'h03), 32'h100, 32'h1);
    expectOut("bad_opcode_err", S_ERR);
    @(negedge iCLK);
    expectOut("err_idle", S_IDLE);
    chk("err_no_ce", ceCnt, c0);

    // Reset during SB MERGE aborts without any write
    w0 = writeCnt;
    issue(sInst(12'h000, 5'd1, 5'd2, 3'd0, 7'h23), 32'h140, 32'hFF);
    @(negedge iCLK);
    expectOut("abort_merge", S_MERGE);
    iRST = 1'b1;
    @(negedge iCLK);
    expectOut("abort_outputs", S_IDLE);
    chk("abort_addr", oRAM_ADDR, 32'h0);
    chk("abort_data", oRAM_DATA, 32'h0);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("abort_no_write", writeCnt, w0);
    chk("abort_mem", mem[10'h050], 32'hCAFEF00D);
    issue(sInst(12'h004, 5'd1, 5'd2, 3'd2, 7'h23), 32'h300, 32'h87654321);
    expectOut("post_abort_write", S_WRITE);
    chk("post_abort_addr", oRAM_ADDR, 32'h304);
    repeat (2) @(negedge iCLK);
    chk("post_abort_mem", mem[10'h0C1], 32'h87654321);

    // iSTART with iRST: request dropped
    iIR = sInst(12'h000, 5'd1, 5'd2, 3'd2, 7'h23);
    iREG_OUT1 = 32'h380;
    iSTART = 1'b1;
    iRST = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    iRST = 1'b0;
    expectOut("start_in_reset", S_IDLE);
    @(negedge iCLK);
    expectOut("start_in_reset_after", S_IDLE);

    // Restart requests while busy are ignored
    w0 = writeCnt;
    c0 = doneCnt;
    @(negedge iCLK);
    iIR = sInst(12'h000, 5'd1, 5'd2, 3'd0, 7'h23);
    iREG_OUT1 = 32'h203;
    iREG_OUT2 = 32'h77;
    iSTART = 1'b1;
    @(negedge iCLK);
    iIR = sInst(12'h000, 5'd1, 5'd2, 3'd2, 7'h23);
    iREG_OUT1 = 32'h3C0;
    iREG_OUT2 = 32'h55555555;
    expectOut("busy_read", S_READ);
    @(negedge iCLK);
    expectOut("busy_merge", S_MERGE);
    @(negedge iCLK);
    expectOut("busy_write", S_WRITE);
    @(negedge iCLK);
    expectOut("busy_done", S_DONE);
    iSTART = 1'b0;
    @(negedge iCLK);
    expectOut("busy_idle", S_IDLE);
    @(negedge iCLK);
    chk("busy_one_write", writeCnt - w0, 32'd1);
    chk("busy_one_done", doneCnt - c0, 32'd1);
    chk("busy_mem_sb", mem[10'h080], 32'h77AB3344);
    chk("busy_mem_untouched", mem[10'h0F0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
